// File: rtl/uart_i2c_cmd_seq.sv
// uart_i2c_cmd_seq: parses UART host commands into I2C master writes and single/polled register reads.
// Define WR_STATUS_EN to return a status byte (0xA5 ok, 0xEE NACK) on the UART after each write.
module uart_i2c_cmd_seq #(
    parameter int POLL_CYCLES    = 50000,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] s_rx_tdata,
    input  logic       s_rx_tvalid,
    output logic       s_rx_tready,
    output logic [7:0] m_tx_tdata,
    output logic       m_tx_tvalid,
    input  logic       m_tx_tready,
    output logic [6:0] m_cmd_address,
    output logic       m_cmd_start,
    output logic       m_cmd_read,
    output logic       m_cmd_write,
    output logic       m_cmd_stop,
    output logic       m_cmd_valid,
    input  logic       m_cmd_ready,
    output logic [7:0] m_wr_tdata,
    output logic       m_wr_tvalid,
    output logic       m_wr_tlast,
    input  logic       m_wr_tready,
    input  logic [7:0] s_rd_tdata,
    input  logic       s_rd_tvalid,
    output logic       s_rd_tready,
    input  logic       missed_ack,
    output logic       busy,
    output logic       err
);
    localparam int MAXC = TIMEOUT_CYCLES > POLL_CYCLES ? TIMEOUT_CYCLES : POLL_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [3:0] {
        IDLE, GET_REG, GET_DATA, WR_CMD, WR_REG, WR_DATA, WR_STAT,
        RD_SET, RD_SETREG, RD_CMD, RD_WAIT, TX_BYTE, POLL_WAIT
    } state_t;

    state_t        state, state_n;
    logic [6:0]    addr, reg_addr;
    logic          rw, conv, stop_req;
    logic [7:0]    wdata, rd_byte;
    logic [CW-1:0] cnt;
    logic          rx_acc, rd_state, tmo, poll_done, cont_ok;

    assign rd_state      = state inside {RD_SET, RD_SETREG, RD_CMD, RD_WAIT, TX_BYTE, POLL_WAIT};
    assign s_rx_tready   = rstn && (state inside {IDLE, GET_REG, GET_DATA} || (rd_state && conv && !stop_req));
    assign rx_acc        = s_rx_tvalid && s_rx_tready;
    assign tmo           = cnt == CW'(TIMEOUT_CYCLES - 1);
    assign poll_done     = cnt == CW'(POLL_CYCLES - 1);
    assign cont_ok       = conv && !stop_req && !rx_acc && !err && !missed_ack;
    assign busy          = state != IDLE;
    assign m_cmd_address = addr;

    always_comb begin
        state_n     = state;
        m_cmd_start = 1'b0;
        m_cmd_read  = 1'b0;
        m_cmd_write = 1'b0;
        m_cmd_stop  = 1'b0;
        m_cmd_valid = 1'b0;
        m_wr_tdata  = 8'h00;
        m_wr_tvalid = 1'b0;
        m_wr_tlast  = 1'b0;
        m_tx_tdata  = 8'h00;
        m_tx_tvalid = 1'b0;
        s_rd_tready = 1'b0;
        case (state)
            IDLE:      state_n = rx_acc ? GET_REG : IDLE;
            GET_REG:   state_n = rx_acc ? (rw ? RD_SET : GET_DATA) : (tmo ? IDLE : GET_REG);
            GET_DATA:  state_n = rx_acc ? WR_CMD : (tmo ? IDLE : GET_DATA);
            WR_CMD: begin
                {m_cmd_valid, m_cmd_start, m_cmd_write, m_cmd_stop} = 4'b1111;
                state_n = m_cmd_ready ? WR_REG : WR_CMD;
            end
            WR_REG: begin
                m_wr_tvalid = 1'b1;
                m_wr_tdata  = {1'b0, reg_addr};
                state_n     = m_wr_tready ? WR_DATA : WR_REG;
            end
            WR_DATA: begin
                m_wr_tvalid = 1'b1;
                m_wr_tlast  = 1'b1;
                m_wr_tdata  = wdata;
                state_n     = m_wr_tready ? WR_STAT : WR_DATA;
            end
            WR_STAT: begin
`ifdef WR_STATUS_EN
                m_tx_tvalid = 1'b1;
                m_tx_tdata  = err ? 8'hEE : 8'hA5;
                state_n     = m_tx_tready ? IDLE : WR_STAT;
`else
                state_n = IDLE;
`endif
            end
            RD_SET: begin
                {m_cmd_valid, m_cmd_start, m_cmd_write} = 3'b111;
                state_n = m_cmd_ready ? RD_SETREG : RD_SET;
            end
            RD_SETREG: begin
                m_wr_tvalid = 1'b1;
                m_wr_tlast  = 1'b1;
                m_wr_tdata  = {1'b0, reg_addr};
                state_n     = m_wr_tready ? RD_CMD : RD_SETREG;
            end
            RD_CMD: begin
                {m_cmd_valid, m_cmd_start, m_cmd_read, m_cmd_stop} = 4'b1111;
                state_n = m_cmd_ready ? RD_WAIT : RD_CMD;
            end
            RD_WAIT: begin
                s_rd_tready = 1'b1;
                state_n     = s_rd_tvalid ? TX_BYTE : RD_WAIT;
            end
            TX_BYTE: begin
                m_tx_tvalid = 1'b1;
                m_tx_tdata  = rd_byte;
                state_n     = m_tx_tready ? (cont_ok ? POLL_WAIT : IDLE) : TX_BYTE;
            end
            POLL_WAIT: state_n = (rx_acc || stop_req || err) ? IDLE : (poll_done ? RD_SET : POLL_WAIT);
            default:   state_n = IDLE;
        endcase
    end

    // cnt restarts on every state change, so it times both inter-byte gaps and poll spacing
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            addr     <= '0;
            rw       <= 1'b0;
            conv     <= 1'b0;
            reg_addr <= '0;
            wdata    <= '0;
            rd_byte  <= '0;
            err      <= 1'b0;
            stop_req <= 1'b0;
            cnt      <= '0;
        end else begin
            state    <= state_n;
            cnt      <= (state_n != state) ? '0 : cnt + 1'b1;
            err      <= missed_ack || (err && !(state == IDLE && rx_acc));
            stop_req <= (state == IDLE) ? 1'b0 : (stop_req || (rd_state && rx_acc));
            if (state == IDLE && rx_acc) {addr, rw} <= s_rx_tdata;
            if (state == GET_REG && rx_acc) {conv, reg_addr} <= s_rx_tdata;
            if (state == GET_DATA && rx_acc) wdata <= s_rx_tdata;
            if (state == RD_WAIT && s_rd_tvalid) rd_byte <= s_rd_tdata;
        end
    end
endmodule
